// File: rtl/vc_weighted_arbiter_pkg.sv
// Shared definitions for the weighted VC arbiter: turn encoding, destination
// bit position and the saturating grant-counter helper.
package vc_weighted_arbiter_pkg;

  // Whose turn it is to be served first.
  typedef enum logic {
    PREF_VC0 = 1'b0,
    PREF_VC1 = 1'b1
  } arb_state_e;

  // Word bit that selects the destination FIFO (0 -> D0, 1 -> D1).
  localparam int DEST_BIT = 4;

  // Width of the consecutive-grant counter (weights are 1..15).
  localparam int CNT_W = 4;

  // Increment a grant counter, saturating at the VC's weight.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] lim);
    logic [CNT_W-1:0] res;
    if (cnt >= lim) begin
      res = lim;
    end else begin
      res = cnt + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/vc_weighted_arbiter_grant_fsm.sv
// Turn/run-length tracker and pop decoder for the two virtual channels.
// Pops are combinational; the turn and grant counter are registered.
module vc_grant_fsm
  import vc_weighted_arbiter_pkg::*;
#(
  parameter int VC0_WEIGHT = 3,
  parameter int VC1_WEIGHT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic active_in,
  input  logic vc0_empty,
  input  logic vc1_empty,
  input  logic d0_afull,
  input  logic d1_afull,
  output logic vc0_pop,
  output logic vc1_pop
);

  localparam logic [CNT_W-1:0] W0 = CNT_W'(VC0_WEIGHT);
  localparam logic [CNT_W-1:0] W1 = CNT_W'(VC1_WEIGHT);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_may_pop;
  logic             w_pop0;
  logic             w_pop1;

  // Turn and consecutive-grant counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= PREF_VC0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Grant decision: serve the preferred VC, fall back to the other when it is empty.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop0      = 1'b0;
    w_pop1      = 1'b0;
    // Reset also blocks pops so nothing is consumed while the pipeline is held.
    w_may_pop   = reset & active_in & ~d0_afull & ~d1_afull;
    w_cnt_inc   = {1'b0, r_cnt} + 5'd1;
    case (r_state)
      PREF_VC0: begin
        if (w_may_pop && !vc0_empty) begin
          w_pop0 = 1'b1;
          if ((w_cnt_inc >= {1'b0, W0}) && !vc1_empty) begin
            w_state_nxt = PREF_VC1;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = sat_inc(r_cnt, W0);
          end
        end else if (w_may_pop && !vc1_empty) begin
          w_pop1      = 1'b1;
          w_state_nxt = PREF_VC1;
          w_cnt_nxt   = 4'd1;
        end else begin
          w_state_nxt = r_state;
          w_cnt_nxt   = r_cnt;
        end
      end
      PREF_VC1: begin
        if (w_may_pop && !vc1_empty) begin
          w_pop1 = 1'b1;
          if ((w_cnt_inc >= {1'b0, W1}) && !vc0_empty) begin
            w_state_nxt = PREF_VC0;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = sat_inc(r_cnt, W1);
          end
        end else if (w_may_pop && !vc0_empty) begin
          w_pop0      = 1'b1;
          w_state_nxt = PREF_VC0;
          w_cnt_nxt   = 4'd1;
        end else begin
          w_state_nxt = r_state;
          w_cnt_nxt   = r_cnt;
        end
      end
      default: begin
        w_state_nxt = PREF_VC0;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign vc0_pop = w_pop0;
  assign vc1_pop = w_pop1;

endmodule

// File: rtl/vc_weighted_arbiter.sv
// Weighted round-robin arbiter between the VC0/VC1 FIFOs and the D0/D1 FIFOs.
// Pop in cycle N, FIFO read data sampled in N+1, push visible in N+2.
module vc_weighted_arbiter
  import vc_weighted_arbiter_pkg::*;
#(
  parameter int data_width = 6,
  parameter int VC0_WEIGHT = 3,
  parameter int VC1_WEIGHT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active_in,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [data_width-1:0] vc0_data,
  input  logic [data_width-1:0] vc1_data,
  input  logic                  d0_afull,
  input  logic                  d1_afull,
  output logic                  vc0_pop,
  output logic                  vc1_pop,
  output logic [data_width-1:0] data_out,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic                  arb_idle
);

  logic                  w_vc0_pop;
  logic                  w_vc1_pop;
  logic                  w_any_pop;
  logic [data_width-1:0] w_word;
  logic                  r_s1_valid;
  logic                  r_s1_src;
  logic [data_width-1:0] r_data;
  logic                  r_push_d0;
  logic                  r_push_d1;
  logic                  r_arb_idle;

  vc_grant_fsm #(
    .VC0_WEIGHT (VC0_WEIGHT),
    .VC1_WEIGHT (VC1_WEIGHT)
  ) u_grant_fsm (
    .clk       (clk),
    .reset     (reset),
    .active_in (active_in),
    .vc0_empty (vc0_empty),
    .vc1_empty (vc1_empty),
    .d0_afull  (d0_afull),
    .d1_afull  (d1_afull),
    .vc0_pop   (w_vc0_pop),
    .vc1_pop   (w_vc1_pop)
  );

  assign w_any_pop = w_vc0_pop | w_vc1_pop;
  // Read data of the VC popped last cycle.
  assign w_word    = r_s1_src ? vc1_data : vc0_data;

  // Stage 1: remember that a word is in flight and which VC it comes from.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_src   <= 1'b0;
    end else begin
      r_s1_valid <= w_any_pop;
      r_s1_src   <= w_vc1_pop;
    end
  end

  // Stage 2: register the word, steer the push by its destination bit, track idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data     <= '0;
      r_push_d0  <= 1'b0;
      r_push_d1  <= 1'b0;
      r_arb_idle <= 1'b1;
    end else begin
      r_push_d0  <= r_s1_valid & ~w_word[DEST_BIT];
      r_push_d1  <= r_s1_valid &  w_word[DEST_BIT];
      r_arb_idle <= ~w_any_pop & ~r_s1_valid;
      if (r_s1_valid) begin
        r_data <= w_word;
      end else begin
        r_data <= r_data;
      end
    end
  end

  assign vc0_pop  = w_vc0_pop;
  assign vc1_pop  = w_vc1_pop;
  assign data_out = r_data;
  assign push_d0  = r_push_d0;
  assign push_d1  = r_push_d1;
  assign arb_idle = r_arb_idle;

endmodule
